// File: rtl/clock_divider_multi.sv
// ---------------------------------------------------------------------------
// clock_divider_multi
//
// Purpose:
//   Multi-channel clock divider. Every channel derives its own registered
//   divided clock and a one-cycle tick strobe from the single source clock
//   clk_in. Each channel has its own divide factor and enable. The channels
//   share only the reset and the phase-align (sync) pulse.
//
// Ports:
//   clk_in    in   1           source clock; all logic uses its rising edge
//   rst       in   1           synchronous, active-high reset
//   en        in   N_CH        per-channel enable
//   sync      in   1           restart all enabled channels in phase
//   div_fact  in   N_CH*WIDTH  packed factors; channel i uses [i*WIDTH +: WIDTH]
//   clk_out   out  N_CH        registered divided clock per channel
//   tick      out  N_CH        one-cycle strobe at the start of each period
//
// Optional feature macro: CLKDIV_GLITCH_FREE_EN
//   Defined   : the active factor is reloaded only at a period boundary, when
//               the channel is idle or disabled, or on sync/rst. A mid-period
//               factor change therefore never changes the current period.
//   Undefined : the active factor follows div_fact on every edge. A change can
//               truncate one period.
// ---------------------------------------------------------------------------
module clock_divider_multi #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 32
) (
  input  logic                  clk_in,
  input  logic                  rst,
  input  logic [N_CH-1:0]       en,
  input  logic                  sync,
  input  logic [N_CH*WIDTH-1:0] div_fact,
  output logic [N_CH-1:0]       clk_out,
  output logic [N_CH-1:0]       tick
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [WIDTH-1:0] w_div;
      logic [WIDTH-1:0] w_half;
      logic [WIDTH-1:0] w_cnt_next;
      logic             w_wrap;
      logic             w_load;
      logic [WIDTH-1:0] r_cnt;
      logic [WIDTH-1:0] r_f_act;
      logic             r_clk;
      logic             r_tick;

      assign w_div  = div_fact[gi*WIDTH +: WIDTH];

      // High phase is ceil(f/2), so odd factors spend the extra cycle high.
      assign w_half = r_f_act - (r_f_act >> 1);

      // Use >= rather than == here. Without glitch-free reload, a smaller
      // factor can arrive while cnt is already past the new terminal count.
      // The channel must wrap at once and must not run up to 2^WIDTH.
      // This path is only used when f_act >= 2, so f_act-1 cannot underflow.
      assign w_wrap     = (r_cnt >= (r_f_act - ONE));
      assign w_cnt_next = w_wrap ? '0 : (r_cnt + ONE);

`ifdef CLKDIV_GLITCH_FREE_EN
      // Reload only where a new period starts.
      assign w_load = w_wrap;
`else
      assign w_load = 1'b1;
`endif

      always_ff @(posedge clk_in) begin
        if (rst || !en[gi]) begin
          r_cnt   <= '0;
          r_clk   <= 1'b0;
          r_tick  <= 1'b0;
          r_f_act <= w_div;
        end else if (sync) begin
          // The freshly loaded factor decides this edge. A zero factor stays idle.
          r_f_act <= w_div;
          r_cnt   <= '0;
          r_clk   <= (w_div != '0);
          r_tick  <= (w_div != '0);
        end else if (r_f_act == '0) begin
          r_cnt   <= '0;
          r_clk   <= 1'b0;
          r_tick  <= 1'b0;
          r_f_act <= w_div;
        end else if (r_f_act == ONE) begin
          // Divide-by-one: every edge is a period boundary.
          r_cnt   <= '0;
          r_clk   <= 1'b1;
          r_tick  <= 1'b1;
          r_f_act <= w_div;
        end else begin
          r_cnt  <= w_cnt_next;
          r_clk  <= (w_cnt_next < w_half);
          r_tick <= (w_cnt_next == '0);
          if (w_load) begin
            r_f_act <= w_div;
          end
        end
      end

      assign clk_out[gi] = r_clk;
      assign tick[gi]    = r_tick;
    end
  endgenerate

endmodule

// File: tb/tb_clock_divider_multi.sv
module tb_clock_divider_multi;

  localparam int N_CH  = 4;
  localparam int WIDTH = 32;

  logic                  clk_in = 1'b0;
  logic                  rst;
  logic [N_CH-1:0]       en;
  logic                  sync;
  logic [N_CH*WIDTH-1:0] div_fact;
  logic [N_CH-1:0]       clk_out;
  logic [N_CH-1:0]       tick;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model. Each channel is described by its position within the
  // current period and the factor it is currently counting with.
  longint m_pos [N_CH];
  longint m_f   [N_CH];
  logic [N_CH-1:0] e_clk;
  logic [N_CH-1:0] e_tick;

  clock_divider_multi #(.N_CH(N_CH), .WIDTH(WIDTH)) dut (
    .clk_in   (clk_in),
    .rst      (rst),
    .en       (en),
    .sync     (sync),
    .div_fact (div_fact),
    .clk_out  (clk_out),
    .tick     (tick)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [N_CH-1:0] obs, input logic [N_CH-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic set_f(input int ch, input longint v);
    logic [WIDTH-1:0] tmp;
    tmp = v[WIDTH-1:0];
    div_fact[ch*WIDTH +: WIDTH] = tmp;
  endtask

  // Advance the model by one edge using the current inputs, wait for the
  // edge, then compare both output vectors.
  task automatic step(input string tag);
    longint d;
    for (int ch = 0; ch < N_CH; ch++) begin
      d = longint'(div_fact[ch*WIDTH +: WIDTH]);
      if (rst || !en[ch]) begin
        m_pos[ch] = 0; m_f[ch] = d; e_clk[ch] = 1'b0; e_tick[ch] = 1'b0;
      end else if (sync) begin
        m_f[ch] = d; m_pos[ch] = 0;
        e_clk[ch] = (d != 0); e_tick[ch] = (d != 0);
      end else if (m_f[ch] <= 1) begin
        m_pos[ch] = 0;
        e_clk[ch] = (m_f[ch] == 1); e_tick[ch] = (m_f[ch] == 1);
        m_f[ch] = d;
      end else begin
        m_pos[ch] = (m_pos[ch] + 1 >= m_f[ch]) ? 0 : m_pos[ch] + 1;
        e_clk[ch]  = (2 * m_pos[ch] < m_f[ch]);
        e_tick[ch] = (m_pos[ch] == 0);
`ifdef CLKDIV_GLITCH_FREE_EN
        if (m_pos[ch] == 0) m_f[ch] = d;
`else
        m_f[ch] = d;
`endif
      end
    end
    @(posedge clk_in);
    #1;
    check({tag, "/clk_out"}, clk_out, e_clk);
    check({tag, "/tick"}, tick, e_tick);
  endtask

  initial begin
    rst = 1'b1; en = 4'b0001; sync = 1'b0; div_fact = '0;
    set_f(0, 2);
    for (int i = 0; i < N_CH; i++) begin m_pos[i] = 0; m_f[i] = 0; end

    // Reset for two cycles: everything must read 0.
    step("reset0");
    step("reset1");
    check("reset_clk_zero", clk_out, 4'b0000);

    // Channel 0 divides by 2: 0,1,0,1 with a tick on each rising edge.
    rst = 1'b0;
    for (int i = 0; i < 8; i++) step("f0_div2");

    // Channel 1 divides by 5: 3 cycles high, then 2 low.
    set_f(1, 5); en = 4'b0011;
    for (int i = 0; i < 15; i++) step("f1_div5");

    // Change the channel-0 factor mid-run, between period boundaries.
    set_f(0, 5);
    for (int i = 0; i < 15; i++) step("f0_change");

    // Four channels at 2,3,4,6, aligned by sync. They all tick together again after 12 cycles.
    set_f(0, 2); set_f(1, 3); set_f(2, 4); set_f(3, 6); en = 4'b1111;
    for (int i = 0; i < 5; i++) step("mix_run");
    sync = 1'b1;
    step("sync_pulse");
    check("sync_all_tick", tick, 4'b1111);
    check("sync_all_high", clk_out, 4'b1111);
    sync = 1'b0;
    for (int i = 0; i < 12; i++) step("after_sync");
    check("realign_12", tick, 4'b1111);
    for (int i = 0; i < 6; i++) step("after_sync2");

    // Factor 1 (always high and ticking), factor 0 (idle), then clear en[2] mid-period.
    set_f(0, 1); set_f(1, 0);
    for (int i = 0; i < 6; i++) step("f1_f0");
    check("div1_high", {3'b000, clk_out[0]}, 4'b0001);
    check("div0_idle", {2'b00, clk_out[1], tick[1]}, 4'b0000);
    step("pre_dis");
    en[2] = 1'b0;
    step("dis2");
    check("dis2_zero", {2'b00, clk_out[2], tick[2]}, 4'b0000);
    en[2] = 1'b1;
    for (int i = 0; i < 8; i++) step("reen2");

    // Reset and sync together: reset wins. Then a normal restart.
    set_f(0, 3); set_f(1, 5);
    for (int i = 0; i < 4; i++) step("pre_rst");
    rst = 1'b1; sync = 1'b1;
    step("rst_sync");
    check("rst_sync_clk", clk_out, 4'b0000);
    check("rst_sync_tick", tick, 4'b0000);
    rst = 1'b0; sync = 1'b0;
    for (int i = 0; i < 10; i++) step("post_rst");

    // Largest legal factor on channel 3. The channel stays high for a very long time.
    set_f(3, 64'hFFFF_FFFF);
    sync = 1'b1;
    step("maxf_sync");
    sync = 1'b0;
    for (int i = 0; i < 5; i++) step("maxf_run");

    // Randomised traffic with small factors.
    for (int i = 0; i < 400; i++) begin
      rst  = ($urandom_range(0, 63) == 0);
      sync = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 15) == 0) en = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) set_f($urandom_range(0, N_CH-1), longint'($urandom_range(0, 9)));
      step("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
